// File: rtl/cory_deser_pkg.sv
//------------------------------------------------------------------------------
// Module   : cory_deser_pkg
// Brief    : Shared width helper for the cory stream blocks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`ifndef CORY_DESER_PKG_SV
`define CORY_DESER_PKG_SV

package cory_deser_pkg;

    // Width of a beat-count field able to hold 0..k.
    function automatic int cory_cw(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

`endif
`default_nettype wire

// File: rtl/cory_queue.sv
//------------------------------------------------------------------------------
// Module   : cory_queue
// Brief    : Valid/ready FIFO of depth Q; Q=0 degenerates to a wire.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cory_queue #(
    parameter int W = 8,
    parameter int Q = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [W-1:0] i_a_d,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [W-1:0] o_z_d,
    input  logic         i_z_r
);

    generate
        if (Q == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ reset_n;
            assign o_z_v    = i_a_v;
            assign o_z_d    = i_a_d;
            assign o_a_r    = i_z_r;
        end else begin : g_fifo
            localparam int P = (Q > 1) ? $clog2(Q) : 1;
            localparam logic [P-1:0] c_last_ptr = P'(Q - 1);
            localparam logic [P:0]   c_depth    = (P + 1)'(Q);

            logic [W-1:0] r_mem [Q];
            logic [P-1:0] r_wp;
            logic [P-1:0] r_rp;
            logic [P:0]   r_cnt;
            logic         w_push;
            logic         w_pop;

            assign o_a_r  = (r_cnt != c_depth);
            assign o_z_v  = (r_cnt != '0);
            assign o_z_d  = r_mem[r_rp];
            assign w_push = i_a_v & o_a_r;
            assign w_pop  = o_z_v & i_z_r;

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wp] <= i_a_d;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push) begin
                        r_wp <= (r_wp == c_last_ptr) ? '0 : r_wp + 1'b1;
                    end
                    if (w_pop) begin
                        r_rp <= (r_rp == c_last_ptr) ? '0 : r_rp + 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_push && w_pop) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cory_deser.sv
//------------------------------------------------------------------------------
// Module   : cory_deser
// Brief    : Packs K N-bit beats (beat 0 in the LSBs) into one A-bit word,
//            with early termination, zero padding and a beat-count tag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cory_deser
    import cory_deser_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2,
    parameter int A = N * K,
    parameter int C = cory_cw(K),
    parameter int Q = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic         i_a_l,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [A-1:0] o_z_d,
    output logic [C-1:0] o_z_c,
    input  logic         i_z_r
);

    localparam logic [C-1:0] c_cnt_last = C'(K - 1);

    logic [A-1:0]   r_acc;
    logic [C-1:0]   r_cnt;
    logic           r_full;
    logic [C-1:0]   r_wcnt;

    logic           w_int_z_r;
    logic           w_acc_b;
    logic           w_done;
    logic           w_drain;
    logic [A-1:0]   w_acc_nxt;
    logic [A+C-1:0] w_q_in;
    logic [A+C-1:0] w_q_out;

    assign o_a_r   = ~r_full | w_int_z_r;
    assign w_acc_b = i_a_v & o_a_r;
    assign w_done  = w_acc_b & ((r_cnt == c_cnt_last) | i_a_l);
    assign w_drain = r_full & w_int_z_r;

    // The first beat of a word wipes every other slot so a short word is zero-padded.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < K; i++) begin
            if (C'(i) == r_cnt) begin
                w_acc_nxt[N*i +: N] = i_a_d;
            end else if (r_cnt == '0) begin
                w_acc_nxt[N*i +: N] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_wcnt <= '0;
        end else begin
            if (w_acc_b) begin
                r_acc <= w_acc_nxt;
            end
            // A completing beat on the draining cycle keeps full set: back-to-back words.
            if (w_done) begin
                r_full <= 1'b1;
                r_wcnt <= r_cnt + 1'b1;
                r_cnt  <= '0;
            end else begin
                if (w_acc_b) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_drain) begin
                    r_full <= 1'b0;
                end
            end
        end
    end

    assign w_q_in = {r_wcnt, r_acc};

    cory_queue #(
        .W (A + C),
        .Q (Q)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_a_v   (r_full),
        .i_a_d   (w_q_in),
        .o_a_r   (w_int_z_r),
        .o_z_v   (o_z_v),
        .o_z_d   (w_q_out),
        .i_z_r   (i_z_r)
    );

    assign o_z_d = w_q_out[A-1:0];
    assign o_z_c = w_q_out[A +: C];

endmodule

`default_nettype wire

// File: tb/tb_cory_deser.sv
//------------------------------------------------------------------------------
// Module   : tb_cory_deser
// Brief    : Directed and randomized checks of cory_deser in four configurations.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cory_deser;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: K=2 Q=0
    logic v0, l0, r0, zv0, zr0;
    logic [7:0]  d0;
    logic [15:0] zd0;
    logic [1:0]  zc0;
    // u1: K=4 Q=0
    logic v1, l1, r1, zv1, zr1;
    logic [7:0]  d1;
    logic [31:0] zd1;
    logic [2:0]  zc1;
    // u2: K=1 Q=0
    logic v2, l2, r2, zv2, zr2;
    logic [7:0]  d2;
    logic [7:0]  zd2;
    logic [0:0]  zc2;
    // u3: K=4 Q=2
    logic v3, l3, r3, zv3, zr3;
    logic [7:0]  d3;
    logic [31:0] zd3;
    logic [2:0]  zc3;

    cory_deser #(.N(8), .K(2), .Q(0)) u0 (
        .clk(clk), .reset_n(reset_n), .i_a_v(v0), .i_a_d(d0), .i_a_l(l0), .o_a_r(r0),
        .o_z_v(zv0), .o_z_d(zd0), .o_z_c(zc0), .i_z_r(zr0));
    cory_deser #(.N(8), .K(4), .Q(0)) u1 (
        .clk(clk), .reset_n(reset_n), .i_a_v(v1), .i_a_d(d1), .i_a_l(l1), .o_a_r(r1),
        .o_z_v(zv1), .o_z_d(zd1), .o_z_c(zc1), .i_z_r(zr1));
    cory_deser #(.N(8), .K(1), .Q(0)) u2 (
        .clk(clk), .reset_n(reset_n), .i_a_v(v2), .i_a_d(d2), .i_a_l(l2), .o_a_r(r2),
        .o_z_v(zv2), .o_z_d(zd2), .o_z_c(zc2), .i_z_r(zr2));
    cory_deser #(.N(8), .K(4), .Q(2)) u3 (
        .clk(clk), .reset_n(reset_n), .i_a_v(v3), .i_a_d(d3), .i_a_l(l3), .o_a_r(r3),
        .o_z_v(zv3), .o_z_d(zd3), .o_z_c(zc3), .i_z_r(zr3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat to u1 and let it be accepted on the next edge.
    task automatic beat1(input logic [7:0] d, input logic l);
        v1 = 1'b1; d1 = d; l1 = l;
        #1 chk("u1_ready", 64'(r1), 64'd1);
        step();
        v1 = 1'b0; l1 = 1'b0;
    endtask

    logic [31:0] mword;
    int          mcnt;
    int          formed;
    int          got;
    bit          acc;
    logic [63:0] expq[$];
    logic [63:0] expw;

    initial begin
        reset_n = 1'b0;
        {v0, l0, d0, zr0} = '0; {v1, l1, d1, zr1} = '0;
        {v2, l2, d2, zr2} = '0; {v3, l3, d3, zr3} = '0;
        zr0 = 1'b1; zr1 = 1'b1; zr2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_zv0", 64'(zv0), 64'd0);
        chk("rst_zv1", 64'(zv1), 64'd0);
        chk("rst_zv3", 64'(zv3), 64'd0);
        chk("rst_ar0", 64'(r0), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic K=2 word
        step();
        v0 = 1'b1; d0 = 8'h11;
        #1 chk("t1_ar_a", 64'(r0), 64'd1);
        step();
        d0 = 8'h22;
        #1 chk("t1_ar_b", 64'(r0), 64'd1);
        step();
        v0 = 1'b0;
        #1;
        chk("t1_zv", 64'(zv0), 64'd1);
        chk("t1_zd", 64'(zd0), 64'h2211);
        chk("t1_zc", 64'(zc0), 64'd2);
        step();
        chk("t1_zv_drop", 64'(zv0), 64'd0);

        // K=4 early termination, then full word, then a 1-beat word
        beat1(8'hA1, 1'b0);
        beat1(8'hB2, 1'b1);
        chk("t2_zv", 64'(zv1), 64'd1);
        chk("t2_zd", 64'(zd1), 64'h0000B2A1);
        chk("t2_zc", 64'(zc1), 64'd2);
        beat1(8'h44, 1'b0);
        beat1(8'h33, 1'b0);
        beat1(8'h22, 1'b0);
        beat1(8'h11, 1'b0);
        chk("t2_zd_full", 64'(zd1), 64'h11223344);
        chk("t2_zc_full", 64'(zc1), 64'd4);
        beat1(8'h55, 1'b1);
        chk("t2_zd_one", 64'(zd1), 64'h00000055);
        chk("t2_zc_one", 64'(zc1), 64'd1);
        step();

        // K=2 backpressure, then drain and accept in the same cycle
        zr0 = 1'b0;
        v0 = 1'b1; d0 = 8'h01;
        step();
        d0 = 8'h02;
        step();
        d0 = 8'h03;
        #1;
        chk("t3_zv", 64'(zv0), 64'd1);
        chk("t3_zd", 64'(zd0), 64'h0201);
        chk("t3_stall", 64'(r0), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_zd", 64'(zd0), 64'h0201);
            chk("t3_hold_ar", 64'(r0), 64'd0);
        end
        zr0 = 1'b1;
        #1 chk("t3_release", 64'(r0), 64'd1);
        step();
        chk("t3_drained", 64'(zv0), 64'd0);
        d0 = 8'h04;
        step();
        v0 = 1'b0;
        #1;
        chk("t3_zv2", 64'(zv0), 64'd1);
        chk("t3_zd2", 64'(zd0), 64'h0403);
        chk("t3_zc2", 64'(zc0), 64'd2);
        step();

        // K=1 streaming, one word per cycle
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) begin
                v2 = 1'b1; d2 = 8'(i);
            end else begin
                v2 = 1'b0;
            end
            #1;
            chk("t4_ar", 64'(r2), 64'd1);
            if (i > 1) begin
                chk("t4_zv", 64'(zv2), 64'd1);
                chk("t4_zd", 64'(zd2), 64'(i - 1));
                chk("t4_zc", 64'(zc2), 64'd1);
            end
            step();
        end
        chk("t4_idle", 64'(zv2), 64'd0);

        // Reset mid-word (u1) and while full (u0)
        zr0 = 1'b0;
        v0 = 1'b1; d0 = 8'hAA; v1 = 1'b1; d1 = 8'h01;
        step();
        d0 = 8'hBB; d1 = 8'h02;
        step();
        v0 = 1'b0; v1 = 1'b0;
        #1 chk("t5_full", 64'(zv0), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_zv0_async", 64'(zv0), 64'd0);
        chk("t5_zv1_async", 64'(zv1), 64'd0);
        chk("t5_ar0", 64'(r0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        zr0 = 1'b1;
        step();
        chk("t5_no_word", 64'(zv1), 64'd0);
        beat1(8'h0A, 1'b0);
        beat1(8'h0B, 1'b0);
        beat1(8'h0C, 1'b0);
        beat1(8'h0D, 1'b0);
        chk("t5_zv", 64'(zv1), 64'd1);
        chk("t5_zd", 64'(zd1), 64'h0D0C0B0A);
        chk("t5_zc", 64'(zc1), 64'd4);
        step();

        // Randomized throttling through a depth-2 queue against a word-building model
        mword = '0; mcnt = 0; formed = 0; got = 0; acc = 1'b0;
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            if (!(v3 && !acc)) begin
                if (formed < 1000) begin
                    v3 = ($urandom_range(0, 9) < 7);
                    d3 = 8'($urandom);
                    l3 = ($urandom_range(0, 7) == 0);
                end else begin
                    v3 = 1'b0; l3 = 1'b0;
                end
            end
            zr3 = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = v3 && r3;
            if (zv3 && zr3) begin
                got++;
                expw = (expq.size() != 0) ? expq.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                chk("rnd_word", {29'b0, zc3, zd3}, expw);
            end
            if (acc) begin
                mword = mword | (32'(d3) << (8 * mcnt));
                mcnt++;
                if (mcnt == 4 || l3) begin
                    expq.push_back({29'b0, 3'(mcnt), mword});
                    formed++;
                    mword = '0;
                    mcnt  = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_count", 64'(got), 64'd1000);
        chk("rnd_left", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
